channel: RTL and testbench
==========================

CHANNEL -- requirements
Module: channel

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits of every token carried.
REQ-002 Parameter HS_PROTOCOL, default P4PhaseBD (4-phase bundled data); P4PhaseBD is the only supported value.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 s_req  input  1  sender request; s_data is valid while high.
REQ-006 s_data  input  WIDTH  sender token.
REQ-007 s_ack  output  1  sender acknowledge.
REQ-008 r_req  output  1  receiver request; r_data is valid while high.
REQ-009 r_data  output  WIDTH  token offered to the receiver.
REQ-010 r_ack  input  1  receiver acknowledge.
REQ-011 full  output  1  one-slot token buffer is occupied.
REQ-012 proto_err  output  1  sticky protocol-violation flag.

Function
REQ-013 The block SHALL be a one-token buffered channel; every token accepted on the sender port is delivered exactly once, in order, on the receiver port.
REQ-014 The sender FSM SHALL have states S_IDLE (s_ack=0) and S_ACKED (s_ack=1).
REQ-015 In S_IDLE, with s_req=1 and full=0, the block SHALL capture s_data into the buffer, set full and go to S_ACKED at the same edge; s_ack is high from the next cycle.
REQ-016 In S_ACKED, with s_req=0, the FSM SHALL return to S_IDLE and s_ack SHALL fall at that edge.
REQ-017 While full=1, s_req=1 in S_IDLE SHALL stall; s_ack stays low and no data is captured.
REQ-018 The receiver FSM SHALL have states R_IDLE (r_req=0), R_REQ (r_req=1) and R_WAIT (r_req=0, waiting for r_ack=0).
REQ-019 In R_IDLE, with full=1, the FSM SHALL go to R_REQ; r_req is high one cycle after full rises.
REQ-020 r_data SHALL equal the buffer register at all times and SHALL remain stable while r_req=1.
REQ-021 In R_REQ, with r_ack=1, the FSM SHALL go to R_WAIT and clear full at the same edge.
REQ-022 In R_WAIT, with r_ack=0, the FSM SHALL go to R_IDLE.
REQ-023 Minimum latency from s_req rising to r_req rising SHALL be 2 clock edges.
REQ-024 Throughput SHALL be at most one token per complete 4-phase cycle on each side.
REQ-025 A new capture is allowed the cycle after full clears; both FSMs evaluate registered full, so no same-edge capture-and-release occurs.
REQ-026 proto_err SHALL set, and remain set until reset, on any of these:
  - r_ack=1 while in R_IDLE;
  - s_data changes while s_req=1 in S_IDLE with full=1.
REQ-027 Data is opaque: no width conversion, and no value is reserved.

Reset
REQ-028 While rst=1, asynchronously:
  - both FSMs SHALL go to their idle states;
  - full, s_ack, r_req and proto_err SHALL be 0;
  - the buffer SHALL be all zeros.
REQ-029 Reset mid-transfer SHALL discard any buffered token; after rst falls, the handshake restarts from idle.
REQ-030 A sender that still holds s_req=1 after reset is treated as a new request.

Structure
REQ-031 The following SHALL live in a shared package used by all CSP-style blocks:
  - the protocol enumeration (P4PhaseBD, with the enumeration open for future protocols);
  - the FSM state typedefs.
REQ-032 The block SHALL be implemented as one module with two always_ff FSMs (sender side, receiver side) sharing the buffer and full register; no sub-module is required.

Verification
REQ-033 Single token: WIDTH=8, send 0xA5 -> r_req rises 2 edges after s_req, r_data=0xA5, s_ack and r_req complete the 4-phase handshake, full returns to 0.
REQ-034 Back-to-back stream: send 0x00, 0x01 ... 0x18 (25 tokens) -> all received in order with no loss or duplication, proto_err=0.
REQ-035 Backpressure: receiver withholds r_ack for 20 cycles while the sender presents 0x3C -> s_ack stays low, full=1, r_data=0x3C throughout; after r_ack, the token is delivered.
REQ-036 Reset mid-transfer: assert rst while r_req=1 holding 0x7E -> all outputs go to 0 immediately; after release and no new s_req, r_req stays 0.
REQ-037 Protocol error: pulse r_ack=1 while r_req=0 -> proto_err=1 and stays 1 until rst.
REQ-038 WIDTH=64 instance: send 0xFFFF_0000_1234_5678 -> the identical value appears on r_data.

Source files
------------

// File: rtl/channel_pkg.sv
// Shared types for CSP-style handshake blocks: protocol selection and FSM state encodings.
package channel_pkg;

    // Left open for future protocols such as 2-phase bundled data.
    typedef enum logic [1:0] {
        P4PhaseBD = 2'd0
    } hs_protocol_e;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ACKED = 1'b1
    } send_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_REQ  = 2'd1,
        R_WAIT = 2'd2
    } recv_state_e;

endpackage

// File: rtl/channel.sv
// One-token buffered 4-phase bundled-data channel with independent sender and receiver FSMs
// sharing a single buffer register and its full flag.
module channel
    import channel_pkg::*;
#(
    parameter int unsigned  WIDTH       = 8,
    parameter hs_protocol_e HS_PROTOCOL = P4PhaseBD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_req,
    input  logic [WIDTH-1:0] s_data,
    output logic             s_ack,
    output logic             r_req,
    output logic [WIDTH-1:0] r_data,
    input  logic             r_ack,
    output logic             full,
    output logic             proto_err
);

    localparam bit IsFourPhase = (HS_PROTOCOL == P4PhaseBD);

    send_state_e      r_sstate, w_sstate_next;
    recv_state_e      r_rstate, w_rstate_next;
    logic             r_full;
    logic [WIDTH-1:0] r_buf;
    logic             r_err;
    logic             r_prev_stall;
    logic [WIDTH-1:0] r_prev_data;

    logic w_capture;
    logic w_release;
    logic w_stall;
    logic w_err;

    // Both sides look only at registered full, so capture and release never share an edge.
    assign w_capture = IsFourPhase && (r_sstate == S_IDLE) && s_req && !r_full;
    assign w_release = (r_rstate == R_REQ) && r_ack;
    assign w_stall   = (r_sstate == S_IDLE) && s_req && r_full;
    assign w_err     = ((r_rstate == R_IDLE) && r_ack) ||
                       (w_stall && r_prev_stall && (s_data != r_prev_data));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sstate <= S_IDLE;
        end else begin
            r_sstate <= w_sstate_next;
        end
    end

    always_comb begin
        w_sstate_next = r_sstate;
        unique case (r_sstate)
            S_IDLE:  if (w_capture) w_sstate_next = S_ACKED;
            S_ACKED: if (!s_req)    w_sstate_next = S_IDLE;
            default: w_sstate_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rstate <= R_IDLE;
        end else begin
            r_rstate <= w_rstate_next;
        end
    end

    always_comb begin
        w_rstate_next = r_rstate;
        unique case (r_rstate)
            R_IDLE:  if (r_full)  w_rstate_next = R_REQ;
            R_REQ:   if (r_ack)   w_rstate_next = R_WAIT;
            R_WAIT:  if (!r_ack)  w_rstate_next = R_IDLE;
            default: w_rstate_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full       <= 1'b0;
            r_buf        <= '0;
            r_err        <= 1'b0;
            r_prev_stall <= 1'b0;
            r_prev_data  <= '0;
        end else begin
            if (w_capture) begin
                r_full <= 1'b1;
                r_buf  <= s_data;
            end else if (w_release) begin
                r_full <= 1'b0;
            end
            if (w_err) begin
                r_err <= 1'b1;
            end
            r_prev_stall <= w_stall;
            r_prev_data  <= s_data;
        end
    end

    always_comb begin
        s_ack     = (r_sstate == S_ACKED);
        r_req     = (r_rstate == R_REQ);
        r_data    = r_buf;
        full      = r_full;
        proto_err = r_err;
    end

endmodule

// File: tb/tb_channel.sv
// Directed plus randomized bench for the one-token channel, with a queue-based token model.
module tb_channel;
    import channel_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_req = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_ack;
    logic        r_req;
    logic [7:0]  r_data;
    logic        r_ack = 1'b0;
    logic        full;
    logic        proto_err;

    logic        s_req64 = 1'b0;
    logic [63:0] s_data64 = '0;
    logic        s_ack64;
    logic        r_req64;
    logic [63:0] r_data64;
    logic        r_ack64 = 1'b0;
    logic        full64;
    logic        proto_err64;

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    channel #(.WIDTH(8), .HS_PROTOCOL(P4PhaseBD)) u_dut (
        .clk(clk), .rst(rst), .s_req(s_req), .s_data(s_data), .s_ack(s_ack),
        .r_req(r_req), .r_data(r_data), .r_ack(r_ack), .full(full), .proto_err(proto_err)
    );

    channel #(.WIDTH(64), .HS_PROTOCOL(P4PhaseBD)) u_dut64 (
        .clk(clk), .rst(rst), .s_req(s_req64), .s_data(s_data64), .s_ack(s_ack64),
        .r_req(r_req64), .r_data(r_data64), .r_ack(r_ack64), .full(full64),
        .proto_err(proto_err64)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_s_ack(input logic v, input string tag);
        bit ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (s_ack === v) begin ok = 1'b1; break; end
        end
        check(tag, 64'(ok), 64'd1);
    endtask

    task automatic wait_r_req(input logic v, input string tag);
        bit ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (r_req === v) begin ok = 1'b1; break; end
        end
        check(tag, 64'(ok), 64'd1);
    endtask

    task automatic send_token(input logic [7:0] d);
        s_data = d;
        s_req  = 1'b1;
        wait_s_ack(1'b1, "s_ack_rise");
        s_req = 1'b0;
        wait_s_ack(1'b0, "s_ack_fall");
    endtask

    task automatic recv_token(input logic [7:0] exp, input string tag);
        wait_r_req(1'b1, "r_req_rise");
        check(tag, 64'(r_data), 64'(exp));
        r_ack = 1'b1;
        wait_r_req(1'b0, "r_req_fall");
        r_ack = 1'b0;
    endtask

    task automatic do_reset();
        s_req = 1'b0;
        r_ack = 1'b0;
        s_req64 = 1'b0;
        r_ack64 = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic xfer64(input logic [63:0] d, input string tag);
        bit ok;
        s_data64 = d;
        s_req64  = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (r_req64 === 1'b1) begin ok = 1'b1; break; end
        end
        check("w64_r_req", 64'(ok), 64'd1);
        check(tag, r_data64, d);
        s_req64 = 1'b0;
        r_ack64 = 1'b1;
        @(negedge clk);
        check("w64_r_req_fall", 64'(r_req64), 64'd0);
        r_ack64 = 1'b0;
        repeat (2) @(negedge clk);
        check("w64_full_clear", 64'(full64), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        // Reset state while rst is held.
        @(negedge clk);
        check("rst_s_ack", 64'(s_ack), 64'd0);
        check("rst_r_req", 64'(r_req), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        check("rst_proto_err", 64'(proto_err), 64'd0);
        check("rst_r_data", 64'(r_data), 64'd0);
        check("rst_r_data64", r_data64, 64'd0);
        do_reset();

        // Single token 0xA5 with cycle-exact latency.
        s_data = 8'hA5;
        s_req  = 1'b1;
        @(negedge clk);
        check("single_s_ack_e1", 64'(s_ack), 64'd1);
        check("single_full_e1", 64'(full), 64'd1);
        check("single_r_req_e1", 64'(r_req), 64'd0);
        @(negedge clk);
        check("single_r_req_e2", 64'(r_req), 64'd1);
        check("single_r_data", 64'(r_data), 64'hA5);
        s_req = 1'b0;
        @(negedge clk);
        check("single_s_ack_fall", 64'(s_ack), 64'd0);
        r_ack = 1'b1;
        @(negedge clk);
        check("single_r_req_fall", 64'(r_req), 64'd0);
        check("single_full_clear", 64'(full), 64'd0);
        r_ack = 1'b0;
        @(negedge clk);

        // Ordered stream 0x00..0x18 with random gaps on both sides.
        fork
            begin
                for (int i = 0; i < 25; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    send_token(8'(i));
                end
            end
            begin
                for (int j = 0; j < 25; j++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    recv_token(8'(j), "stream_data");
                end
            end
        join
        check("stream_proto_err", 64'(proto_err), 64'd0);
        check("stream_full_empty", 64'(full), 64'd0);

        // Random data stream checked against a FIFO model of accepted tokens.
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    logic [7:0] d;
                    d = 8'($urandom);
                    repeat ($urandom_range(0, 4)) @(negedge clk);
                    exp_q.push_back(64'(d));
                    send_token(d);
                end
            end
            begin
                for (int j = 0; j < 30; j++) begin
                    logic [63:0] e;
                    repeat ($urandom_range(0, 4)) @(negedge clk);
                    wait_r_req(1'b1, "rand_r_req");
                    e = exp_q.pop_front();
                    check("rand_data", 64'(r_data), e);
                    r_ack = 1'b1;
                    wait_r_req(1'b0, "rand_r_req_fall");
                    r_ack = 1'b0;
                end
            end
        join
        check("rand_proto_err", 64'(proto_err), 64'd0);

        // Backpressure: 0x3C held in the buffer while the next token stalls.
        send_token(8'h3C);
        s_data = 8'hC3;
        s_req  = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("bp_s_ack", 64'(s_ack), 64'd0);
            check("bp_full", 64'(full), 64'd1);
            check("bp_r_data", 64'(r_data), 64'h3C);
        end
        check("bp_r_req", 64'(r_req), 64'd1);
        r_ack = 1'b1;
        @(negedge clk);
        check("bp_release", 64'(full), 64'd0);
        r_ack = 1'b0;
        wait_s_ack(1'b1, "bp_second_ack");
        s_req = 1'b0;
        recv_token(8'hC3, "bp_second_data");
        check("bp_proto_err", 64'(proto_err), 64'd0);
        @(negedge clk);

        // Reset in the middle of a transfer.
        send_token(8'h7E);
        wait_r_req(1'b1, "mid_r_req");
        check("mid_r_data", 64'(r_data), 64'h7E);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_r_req", 64'(r_req), 64'd0);
        check("mid_rst_full", 64'(full), 64'd0);
        check("mid_rst_s_ack", 64'(s_ack), 64'd0);
        check("mid_rst_r_data", 64'(r_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("post_rst_r_req", 64'(r_req), 64'd0);
        end

        // Request held across reset counts as a new request.
        s_data = 8'h99;
        s_req  = 1'b1;
        rst    = 1'b1;
        @(negedge clk);
        check("held_req_in_rst", 64'(s_ack), 64'd0);
        rst = 1'b0;
        wait_s_ack(1'b1, "held_req_ack");
        s_req = 1'b0;
        recv_token(8'h99, "held_req_data");

        // Spurious r_ack while idle is sticky until reset.
        @(negedge clk);
        check("perr_before", 64'(proto_err), 64'd0);
        r_ack = 1'b1;
        @(negedge clk);
        r_ack = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("perr_sticky", 64'(proto_err), 64'd1);
        end
        do_reset();
        check("perr_cleared", 64'(proto_err), 64'd0);

        // Sender changing data during a stall.
        send_token(8'h55);
        s_data = 8'h66;
        s_req  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("perr_stall_stable", 64'(proto_err), 64'd0);
        s_data = 8'h67;
        @(negedge clk);
        check("perr_stall_change", 64'(proto_err), 64'd1);
        do_reset();

        // 64-bit instance.
        xfer64(64'hFFFF_0000_1234_5678, "w64_directed");
        for (int i = 0; i < 4; i++) begin
            xfer64({$urandom, $urandom}, "w64_random");
        end
        check("w64_proto_err", 64'(proto_err64), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
